// File: rtl/writeback_reg_writer.sv
// Register-file side of the RoCE writeback path: latches one batch of per-QP and
// global-counter writeback values, then drains them one per cycle into the reg-file write port.
module writeback_reg_writer #(
  parameter int unsigned ADDR_WIDTH          = 32,
  parameter int unsigned QP_STRIDE           = 'h100,
  parameter int unsigned CQHEADi_BASE        = 'h20028,
  parameter int unsigned SQPSNi_BASE         = 'h20024,
  parameter int unsigned LSTRQREQi_BASE      = 'h2002C,
  parameter int unsigned INSRRPKTCNT_ADDR    = 'h10100,
  parameter int unsigned INAMPKTCNT_ADDR     = 'h10104,
  parameter int unsigned INNCKPKTSTS_ADDR    = 'h10108,
  parameter int unsigned OUTAMPKTCNT_ADDR    = 'h1010C,
  parameter int unsigned OUTNAKPKTCNT_ADDR   = 'h10110,
  parameter int unsigned OUTIOPKTCNT_ADDR    = 'h10114,
  parameter int unsigned OUTRDRSPPKTCNT_ADDR = 'h10118
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  wb_valid_i,
  output logic                  wb_ready_o,
  input  logic                  CQHEADi_wb_valid_i,
  input  logic                  SQPSNi_wb_valid_i,
  input  logic                  LSTRQREQi_wb_valid_i,
  input  logic                  INSRRPKTCNT_wb_valid_i,
  input  logic                  INAMPKTCNT_wb_valid_i,
  input  logic                  INNCKPKTSTS_wb_valid_i,
  input  logic                  OUTAMPKTCNT_wb_valid_i,
  input  logic                  OUTNAKPKTCNT_wb_valid_i,
  input  logic                  OUTIOPKTCNT_wb_valid_i,
  input  logic                  OUTRDRSPPKTCNT_wb_valid_i,
  input  logic [39:0]           CQHEADi_wb_i,
  input  logic [39:0]           SQPSNi_wb_i,
  input  logic [39:0]           LSTRQREQi_wb_i,
  input  logic [31:0]           INSRRPKTCNT_wb_i,
  input  logic [31:0]           INAMPKTCNT_wb_i,
  input  logic [31:0]           INNCKPKTSTS_wb_i,
  input  logic [31:0]           OUTAMPKTCNT_wb_i,
  input  logic [15:0]           OUTNAKPKTCNT_wb_i,
  input  logic [31:0]           OUTIOPKTCNT_wb_i,
  input  logic [31:0]           OUTRDRSPPKTCNT_wb_i,
  output logic                  reg_wr_valid_o,
  input  logic                  reg_wr_ready_i,
  output logic [ADDR_WIDTH-1:0] reg_wr_addr_o,
  output logic [31:0]           reg_wr_data_o
);

  // state | meaning
  // IDLE  | nothing pending, batch input accepted
  // DRAIN | pending bitmap non-zero, writing lowest set entry
  typedef enum logic {IDLE, DRAIN} state_e;

  state_e      state_q, state_d;
  logic [9:0]  pend_q, pend_d;
  logic [9:0]  ch_valid;
  logic        capture;
  logic [3:0]  sel;

  logic [39:0] cqhead_q, sqpsn_q, lstrqreq_q;
  logic [31:0] insrr_q, inam_q, innck_q, outam_q, outio_q, outrdrsp_q;
  logic [15:0] outnak_q;

  assign ch_valid = {OUTRDRSPPKTCNT_wb_valid_i, OUTIOPKTCNT_wb_valid_i, OUTNAKPKTCNT_wb_valid_i,
                     OUTAMPKTCNT_wb_valid_i, INNCKPKTSTS_wb_valid_i, INAMPKTCNT_wb_valid_i,
                     INSRRPKTCNT_wb_valid_i, LSTRQREQi_wb_valid_i, SQPSNi_wb_valid_i,
                     CQHEADi_wb_valid_i};

  // Ready is held low through reset so nothing is latched before the block is up.
  assign wb_ready_o = (state_q == IDLE) && !rst_i;
  assign capture    = wb_valid_i && wb_ready_o;

  function automatic logic [ADDR_WIDTH-1:0] qp_addr(input logic [ADDR_WIDTH-1:0] base,
                                                    input logic [7:0]            qp);
    return base + ADDR_WIDTH'(qp) * ADDR_WIDTH'(QP_STRIDE);
  endfunction

  always_comb begin
    sel = '0;
    for (int k = 9; k >= 0; k--) begin
      if (pend_q[k]) sel = 4'(k);
    end
  end

  always_comb begin
    state_d = state_q;
    pend_d  = pend_q;
    case (state_q)
      IDLE: begin
        if (capture) begin
          pend_d = ch_valid;
          if (|ch_valid) state_d = DRAIN;
        end
      end
      DRAIN: begin
        if (reg_wr_ready_i) pend_d = pend_q & ~(10'b1 << sel);
        if (pend_d == '0) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      pend_q  <= '0;
    end else begin
      state_q <= state_d;
      pend_q  <= pend_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (capture) begin
      if (ch_valid[0]) cqhead_q   <= CQHEADi_wb_i;
      if (ch_valid[1]) sqpsn_q    <= SQPSNi_wb_i;
      if (ch_valid[2]) lstrqreq_q <= LSTRQREQi_wb_i;
      if (ch_valid[3]) insrr_q    <= INSRRPKTCNT_wb_i;
      if (ch_valid[4]) inam_q     <= INAMPKTCNT_wb_i;
      if (ch_valid[5]) innck_q    <= INNCKPKTSTS_wb_i;
      if (ch_valid[6]) outam_q    <= OUTAMPKTCNT_wb_i;
      if (ch_valid[7]) outnak_q   <= OUTNAKPKTCNT_wb_i;
      if (ch_valid[8]) outio_q    <= OUTIOPKTCNT_wb_i;
      if (ch_valid[9]) outrdrsp_q <= OUTRDRSPPKTCNT_wb_i;
    end
  end

  always_comb begin
    reg_wr_valid_o = (state_q == DRAIN);
    reg_wr_addr_o  = '0;
    reg_wr_data_o  = '0;
    if (state_q == DRAIN) begin
      case (sel)
        4'd0: begin
          reg_wr_addr_o = qp_addr(ADDR_WIDTH'(CQHEADi_BASE), cqhead_q[39:32]);
          reg_wr_data_o = cqhead_q[31:0];
        end
        4'd1: begin
          reg_wr_addr_o = qp_addr(ADDR_WIDTH'(SQPSNi_BASE), sqpsn_q[39:32]);
          reg_wr_data_o = sqpsn_q[31:0];
        end
        4'd2: begin
          reg_wr_addr_o = qp_addr(ADDR_WIDTH'(LSTRQREQi_BASE), lstrqreq_q[39:32]);
          reg_wr_data_o = lstrqreq_q[31:0];
        end
        4'd3: begin
          reg_wr_addr_o = ADDR_WIDTH'(INSRRPKTCNT_ADDR);
          reg_wr_data_o = insrr_q;
        end
        4'd4: begin
          reg_wr_addr_o = ADDR_WIDTH'(INAMPKTCNT_ADDR);
          reg_wr_data_o = inam_q;
        end
        4'd5: begin
          reg_wr_addr_o = ADDR_WIDTH'(INNCKPKTSTS_ADDR);
          reg_wr_data_o = innck_q;
        end
        4'd6: begin
          reg_wr_addr_o = ADDR_WIDTH'(OUTAMPKTCNT_ADDR);
          reg_wr_data_o = outam_q;
        end
        4'd7: begin
          reg_wr_addr_o = ADDR_WIDTH'(OUTNAKPKTCNT_ADDR);
          reg_wr_data_o = {16'h0, outnak_q};
        end
        4'd8: begin
          reg_wr_addr_o = ADDR_WIDTH'(OUTIOPKTCNT_ADDR);
          reg_wr_data_o = outio_q;
        end
        4'd9: begin
          reg_wr_addr_o = ADDR_WIDTH'(OUTRDRSPPKTCNT_ADDR);
          reg_wr_data_o = outrdrsp_q;
        end
        default: begin
          reg_wr_addr_o = '0;
          reg_wr_data_o = '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_writeback_reg_writer.sv
// Bench for writeback_reg_writer: directed and random batches checked against a
// list-of-writes model built from the channel address/data rules.
module tb_writeback_reg_writer;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        wb_valid_i;
  logic        wb_ready_o;
  logic [9:0]  chv;
  logic [39:0] qpd [3];
  logic [31:0] cnt [7];
  logic        reg_wr_valid_o;
  logic        reg_wr_ready_i;
  logic [31:0] reg_wr_addr_o;
  logic [31:0] reg_wr_data_o;

  int vectors     = 0;
  int miscompares = 0;

  logic [63:0] expq [$];

  always #5 clk_i = ~clk_i;

  writeback_reg_writer dut (
    .clk_i                     (clk_i),
    .rst_i                     (rst_i),
    .wb_valid_i                (wb_valid_i),
    .wb_ready_o                (wb_ready_o),
    .CQHEADi_wb_valid_i        (chv[0]),
    .SQPSNi_wb_valid_i         (chv[1]),
    .LSTRQREQi_wb_valid_i      (chv[2]),
    .INSRRPKTCNT_wb_valid_i    (chv[3]),
    .INAMPKTCNT_wb_valid_i     (chv[4]),
    .INNCKPKTSTS_wb_valid_i    (chv[5]),
    .OUTAMPKTCNT_wb_valid_i    (chv[6]),
    .OUTNAKPKTCNT_wb_valid_i   (chv[7]),
    .OUTIOPKTCNT_wb_valid_i    (chv[8]),
    .OUTRDRSPPKTCNT_wb_valid_i (chv[9]),
    .CQHEADi_wb_i              (qpd[0]),
    .SQPSNi_wb_i               (qpd[1]),
    .LSTRQREQi_wb_i            (qpd[2]),
    .INSRRPKTCNT_wb_i          (cnt[0]),
    .INAMPKTCNT_wb_i           (cnt[1]),
    .INNCKPKTSTS_wb_i          (cnt[2]),
    .OUTAMPKTCNT_wb_i          (cnt[3]),
    .OUTNAKPKTCNT_wb_i         (cnt[4][15:0]),
    .OUTIOPKTCNT_wb_i          (cnt[5]),
    .OUTRDRSPPKTCNT_wb_i       (cnt[6]),
    .reg_wr_valid_o            (reg_wr_valid_o),
    .reg_wr_ready_i            (reg_wr_ready_i),
    .reg_wr_addr_o             (reg_wr_addr_o),
    .reg_wr_data_o             (reg_wr_data_o)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Channel k -> register address, from the address map.
  function automatic logic [31:0] m_addr(input int k);
    logic [31:0] gaddr [7];
    gaddr = '{32'h10100, 32'h10104, 32'h10108, 32'h1010C, 32'h10110, 32'h10114, 32'h10118};
    case (k)
      0:       return 32'h20028 + 32'(qpd[0][39:32]) * 32'h100;
      1:       return 32'h20024 + 32'(qpd[1][39:32]) * 32'h100;
      2:       return 32'h2002C + 32'(qpd[2][39:32]) * 32'h100;
      default: return gaddr[k-3];
    endcase
  endfunction

  function automatic logic [31:0] m_data(input int k);
    if (k < 3)  return qpd[k][31:0];
    if (k == 7) return {16'h0, cnt[4][15:0]};
    return cnt[k-3];
  endfunction

  // Entered away from the clock edge with the block idle. mode: 0 ready always high,
  // 1 random ready, 2 ready low for the first three drain cycles. hold_v is driven
  // upstream during the drain and must not be taken until the batch is finished.
  task automatic run_batch(input logic [9:0] v, input bit force_wb, input int mode,
                           input logic [9:0] hold_v);
    int n, idx, low, stalls, budget;
    expq.delete();
    for (int k = 0; k < 10; k++) if (v[k]) expq.push_back({m_addr(k), m_data(k)});
    n = expq.size();
    check("ready_before_batch", 64'(wb_ready_o), 64'd1);
    chv        = v;
    wb_valid_i = (|v) | force_wb;
    @(posedge clk_i); #1;
    chv        = hold_v;
    wb_valid_i = |hold_v;
    idx = 0; low = 0; stalls = 0; budget = 0;
    forever begin
      case (mode)
        0:       reg_wr_ready_i = 1'b1;
        1:       reg_wr_ready_i = ($urandom_range(0, 3) != 0);
        default: reg_wr_ready_i = (low >= 3);
      endcase
      @(negedge clk_i);
      if (wb_ready_o) break;
      low++;
      if (reg_wr_valid_o) begin
        check("write_within_batch", 64'(idx < n), 64'd1);
        if (idx < n) begin
          check("wr_addr", 64'(reg_wr_addr_o), 64'(expq[idx][63:32]));
          check("wr_data", 64'(reg_wr_data_o), 64'(expq[idx][31:0]));
        end
        if (reg_wr_ready_i) idx++;
        else stalls++;
      end
      budget++;
      if (budget > 300) begin
        check("drain_timeout", 64'(budget), 64'd0);
        break;
      end
      @(posedge clk_i); #1;
    end
    check("writes_done", 64'(idx), 64'(n));
    check("ready_low_cycles", 64'(low), 64'(n + stalls));
  endtask

  initial begin
    logic [9:0] v5;
    rst_i          = 1'b1;
    wb_valid_i     = 1'b0;
    chv            = '0;
    reg_wr_ready_i = 1'b0;
    for (int i = 0; i < 3; i++) qpd[i] = '0;
    for (int i = 0; i < 7; i++) cnt[i] = '0;
    repeat (3) @(posedge clk_i);
    @(negedge clk_i);
    check("rst_wb_ready", 64'(wb_ready_o), 64'd0);
    check("rst_wr_valid", 64'(reg_wr_valid_o), 64'd0);
    check("rst_wr_addr", 64'(reg_wr_addr_o), 64'd0);
    check("rst_wr_data", 64'(reg_wr_data_o), 64'd0);
    rst_i = 1'b0;
    #1;
    check("wb_ready_after_rst", 64'(wb_ready_o), 64'd1);
    @(negedge clk_i);

    // single CQHEAD entry, QP 5
    qpd[0] = 40'h05_0000_0010;
    run_batch(10'b00_0000_0001, 1'b0, 0, 10'b0);

    // full batch, NAK counter zero-extended
    qpd[0] = 40'h01_1111_1111; qpd[1] = 40'h02_2222_2222; qpd[2] = 40'h03_3333_3333;
    for (int i = 0; i < 7; i++) cnt[i] = 32'hC000_0000 + 32'(i);
    cnt[4] = 32'hDEAD_BEEF;
    run_batch(10'h3FF, 1'b0, 0, 10'b0);

    // backpressure on the first of two entries
    qpd[1] = 40'h02_0000_1234;
    cnt[1] = 32'hAA;
    run_batch(10'b00_0001_0010, 1'b0, 2, 10'b0);

    // upstream holds LSTRQREQ QP 255 during a drain
    cnt[0] = 32'h1357; cnt[2] = 32'h2468;
    qpd[2] = 40'hFF_0BAD_F00D;
    run_batch(10'b00_0010_1000, 1'b0, 0, 10'b00_0000_0100);
    run_batch(10'b00_0000_0100, 1'b0, 0, 10'b0);

    // reset in the middle of a 5-entry drain
    v5 = 10'b10_0101_0011;
    expq.delete();
    for (int k = 0; k < 10; k++) if (v5[k]) expq.push_back({m_addr(k), m_data(k)});
    chv = v5; wb_valid_i = 1'b1; reg_wr_ready_i = 1'b1;
    @(posedge clk_i); #1;
    chv = '0; wb_valid_i = 1'b0;
    for (int w = 0; w < 2; w++) begin
      @(negedge clk_i);
      check("rst5_wr_valid", 64'(reg_wr_valid_o), 64'd1);
      check("rst5_wr_addr", 64'(reg_wr_addr_o), 64'(expq[w][63:32]));
      @(posedge clk_i); #1;
    end
    @(negedge clk_i);
    check("rst5_inflight_addr", 64'(reg_wr_addr_o), 64'(expq[2][63:32]));
    rst_i = 1'b1;
    @(posedge clk_i); #1;
    check("rst5_wr_valid_after_rst", 64'(reg_wr_valid_o), 64'd0);
    check("rst5_wb_ready_in_rst", 64'(wb_ready_o), 64'd0);
    @(negedge clk_i);
    rst_i = 1'b0;
    for (int c = 0; c < 3; c++) begin
      #1;
      check("rst5_wb_ready_after", 64'(wb_ready_o), 64'd1);
      check("rst5_no_write", 64'(reg_wr_valid_o), 64'd0);
      @(negedge clk_i);
    end

    // wb_valid_i with no channel valid
    run_batch(10'b0, 1'b1, 0, 10'b0);
    check("empty_no_write", 64'(reg_wr_valid_o), 64'd0);

    // random batches with random backpressure
    for (int b = 0; b < 30; b++) begin
      for (int i = 0; i < 3; i++) qpd[i] = {8'($urandom), 32'($urandom)};
      for (int i = 0; i < 7; i++) cnt[i] = 32'($urandom);
      if (b % 10 == 9) run_batch(10'b0, 1'b1, 1, 10'b0);
      else             run_batch(10'($urandom_range(1, 1023)), 1'b0, 1, 10'b0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
